ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Upstream of the chord/tone mapper: turns the raw PS/2 keyboard bus into a stable "currently held key" scan code on key_code, which the mapper decodes every clk.
- Contains a bit-level PS/2 frame receiver (synchroniser, edge detect, frame FSM, parity check, timeout) and a make/break tracker (F0/E0 prefix handling).
- key_code is 8'h00 when no key is held. The mapper treats 8'h00 as silence.

Parameters:
- TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- CLEAR_ON_ANY_BREAK, 0, 1: any break code clears key_code; 0: only a break matching the held code clears it.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- key_code  out  8  scan code of held key; 8'h00 = none.
- key_strobe  out  1  1-cycle pulse whenever key_code changes value.
- rx_byte  out  8  last correctly received byte.
- rx_valid  out  1  1-cycle pulse when rx_byte is updated.
- frame_err  out  1  1-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset (async assert, sync release): key_code = 0, rx_byte = 0, all pulses 0, FSM in IDLE, break and ext flags cleared. Synchroniser flops reset to 1, because the bus idles high.
- Synchronise: both lines pass through 2-FF synchronisers. fall = (prev_sync_clk == 1 && sync_clk == 0). All sampling of sync_data happens only in a fall cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE, on fall: data = 0 -> DATA, bit count = 0. Data = 1 -> stay in IDLE and pulse frame_err.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: capture the stop bit -> IDLE.
  - Frame is good if XOR(data[7:0], parity) = 1 (odd parity) and stop = 1.
  - Good frame: rx_byte updated and rx_valid pulsed in the cycle after the stop-bit fall.
  - Bad frame: frame_err pulses in that same cycle, and the byte is dropped.
- Timeout:
  - The counter runs only while not in IDLE and clears on every fall.
  - At TIMEOUT_CYCLES-1 the FSM returns to IDLE, frame_err pulses, and the partial byte is discarded. Break/ext flags are untouched.
- Tracker: acts only on an rx_valid byte.
  - 8'hF0: set the break flag, no output change.
  - 8'hE0: set the ext flag (see Optional Feature).
  - Other byte with break set: clear key_code if byte == key_code or CLEAR_ON_ANY_BREAK = 1, otherwise keep it. Clear break and ext.
  - Other byte with break clear (make): key_code <= byte. Clear ext. Typematic repeat of the same code leaves key_code unchanged, so there is no key_strobe.
  - key_strobe is asserted in the same cycle key_code takes its new value (1 cycle after rx_valid).
  - A make of a new key while another is held replaces key_code: last key wins.
  - A break of a non-held key (CLEAR_ON_ANY_BREAK = 0) is ignored.
- Simultaneous events: a timeout and a fall in the same cycle are resolved as the fall (counter clears, no error).
- Mid-frame reset returns everything to reset values immediately. The keyboard's next frame is received normally.

Optional Feature:
- Macro: PS2_EXT_FILTER_EN.
- Defined: a make or break code following E0 is dropped entirely, so key_code and break state are unchanged except that ext and break are cleared. This prevents extended keys (e.g. keypad Enter E0 5A) aliasing onto note keys.
- Not defined: E0 is ignored, and the following code is processed as a normal make/break.

Test Plan:
- Send frame 8'h1C (parity 0, stop 1) -> rx_valid pulse with rx_byte = 8'h1C; key_code = 8'h1C with key_strobe 1 cycle later.
- Send 1C, then F0, then 1C -> key_code 8'h1C, then 8'h00; exactly 2 key_strobe pulses.
- Send 1C, 1B, F0 1C with CLEAR_ON_ANY_BREAK = 0 -> key_code stays 8'h1B; with = 1 -> 8'h00.
- Frame 8'h23 with a wrong parity bit, then a frame with stop = 0 -> 2 frame_err pulses, no rx_valid, key_code unchanged.
- Send 4 bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulse; the next full frame 8'h2B is received correctly.
- Send E0 5A: macro defined -> key_code stays 8'h00; macro undefined -> key_code = 8'h5A. Also assert rst_n mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: bundle of the PS/2 bus lines and the tracker's outputs.
//
// Handshake: there is no backpressure. rx_valid, key_strobe and frame_err are
// single-cycle pulses; a consumer must sample rx_byte in the rx_valid cycle and
// key_code at any time (it is held until the next change, flagged by key_strobe).
//
// dbg_* signals expose the frame FSM state and the break/ext flags so checkers
// can bind to them without reaching into the design.
interface ps2_key_tracker_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_strobe;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic [1:0] dbg_state;
  logic       dbg_break;
  logic       dbg_ext;

  // Design side: consumes the raw PS/2 lines, produces the decoded results.
  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output key_code,
    output key_strobe,
    output rx_byte,
    output rx_valid,
    output frame_err,
    output dbg_state,
    output dbg_break,
    output dbg_ext
  );

  // Keyboard / environment side.
  modport master (
    output ps2_clk,
    output ps2_data,
    input  key_code,
    input  key_strobe,
    input  rx_byte,
    input  rx_valid,
    input  frame_err,
    input  dbg_state,
    input  dbg_break,
    input  dbg_ext
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 frame receiver plus make/break tracker.
//
// Turns the raw PS/2 keyboard bus into the scan code of the currently held key
// (8'h00 = nothing held). Frames are 11 bits: start(0), 8 data bits LSB first,
// odd parity, stop(1), sampled on falling edges of the PS/2 clock.
//
// Optional feature macro: PS2_EXT_FILTER_EN
//   defined     - a make/break following an E0 prefix is dropped entirely
//                 (only the ext and break flags are cleared).
//   not defined - E0 only sets the ext flag; the next code is handled normally.
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES     = 50000,
  parameter bit CLEAR_ON_ANY_BREAK = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  ps2_key_tracker_if.slave bus
);

  localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  // Synchronisers (idle-high bus, so they reset to 1)
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;

  // Frame receiver
  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_tmo_cnt;
  logic          w_timeout;
  logic [7:0]    r_rx_byte;
  logic          r_rx_valid;
  logic          r_frame_err;

  // Tracker
  logic [7:0] r_key_code;
  logic       r_key_strobe;
  logic       r_break;
  logic       r_ext;
  logic [7:0] w_key_next;
  logic       w_break_next;
  logic       w_ext_next;

  // Two-flop synchronisers on both lines plus one extra clock stage for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= bus.ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= bus.ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  // A fall in the same cycle as the terminal count wins: no timeout then.
  assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tmo_cnt == TMO_LAST);

  // Inactivity counter: idle while waiting for a start bit, restarted by every fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_fall || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Frame FSM: samples data only on PS/2 clock falls, emits rx_valid/frame_err pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_parity    <= 1'b0;
      r_rx_byte   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_parity <= r_dat_s2;
            r_state  <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if ((^{r_shift, r_parity}) && r_dat_s2) begin
              r_rx_byte  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        endcase
      end else if (w_timeout) begin
        // Abandon the partial frame; tracker flags are deliberately left alone.
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
      end
    end
  end

  // Tracker next-state: interpret each received byte as prefix, make or break.
  always_comb begin
    w_key_next   = r_key_code;
    w_break_next = r_break;
    w_ext_next   = r_ext;
    if (r_rx_valid) begin
      if (r_rx_byte == CODE_BREAK) begin
        w_break_next = 1'b1;
      end else if (r_rx_byte == CODE_EXT) begin
        w_ext_next = 1'b1;
      end else begin
`ifdef PS2_EXT_FILTER_EN
        if (r_ext) begin
          w_break_next = 1'b0;
          w_ext_next   = 1'b0;
        end else
`endif
        if (r_break) begin
          if ((r_rx_byte == r_key_code) || CLEAR_ON_ANY_BREAK) begin
            w_key_next = 8'h00;
          end
          w_break_next = 1'b0;
          w_ext_next   = 1'b0;
        end else begin
          w_key_next = r_rx_byte;
          w_ext_next = 1'b0;
        end
      end
    end
  end

  // Tracker registers; key_strobe rises together with the new key_code value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_code   <= 8'h00;
      r_key_strobe <= 1'b0;
      r_break      <= 1'b0;
      r_ext        <= 1'b0;
    end else begin
      r_key_code   <= w_key_next;
      r_key_strobe <= (w_key_next != r_key_code);
      r_break      <= w_break_next;
      r_ext        <= w_ext_next;
    end
  end

  assign bus.key_code   = r_key_code;
  assign bus.key_strobe = r_key_strobe;
  assign bus.rx_byte    = r_rx_byte;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.dbg_state  = r_state;
  assign bus.dbg_break  = r_break;
  assign bus.dbg_ext    = r_ext;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: drives PS/2 frames into two tracker instances
// (CLEAR_ON_ANY_BREAK = 0 and 1) and compares them against a byte-level model.
module tb_ps2_key_tracker;

  localparam int TMO  = 200;
  localparam int HALF = 10;
`ifdef PS2_EXT_FILTER_EN
  localparam bit EXT_FILTER = 1'b1;
`else
  localparam bit EXT_FILTER = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  always #5 clk = ~clk;

  ps2_key_tracker_if if0 ();
  ps2_key_tracker_if if1 ();

  assign if0.ps2_clk  = ps2_clk;
  assign if0.ps2_data = ps2_data;
  assign if1.ps2_clk  = ps2_clk;
  assign if1.ps2_data = ps2_data;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TMO), .CLEAR_ON_ANY_BREAK(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  ps2_key_tracker #(.TIMEOUT_CYCLES(TMO), .CLEAR_ON_ANY_BREAK(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  logic [7:0] kc[2];
  logic [7:0] rxb[2];
  logic       stb[2];
  logic       rxv[2];
  logic       ferr[2];
  logic [1:0] st[2];

  assign kc[0]   = if0.key_code;
  assign kc[1]   = if1.key_code;
  assign rxb[0]  = if0.rx_byte;
  assign rxb[1]  = if1.rx_byte;
  assign stb[0]  = if0.key_strobe;
  assign stb[1]  = if1.key_strobe;
  assign rxv[0]  = if0.rx_valid;
  assign rxv[1]  = if1.rx_valid;
  assign ferr[0] = if0.frame_err;
  assign ferr[1] = if1.frame_err;
  assign st[0]   = if0.dbg_state;
  assign st[1]   = if1.dbg_state;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int vld_cnt[2]   = '{0, 0};
  int err_cnt[2]   = '{0, 0};
  int stb_cnt[2]   = '{0, 0};
  int proto_bad[2] = '{0, 0};
  logic [7:0] prev_kc[2] = '{8'h00, 8'h00};
  logic       prev_vld[2] = '{1'b0, 1'b0};

  // Reference model state
  logic [7:0] m_key[2] = '{8'h00, 8'h00};
  bit         m_brk[2] = '{1'b0, 1'b0};
  bit         m_ext[2] = '{1'b0, 1'b0};
  int         exp_stb[2] = '{0, 0};
  int         exp_vld = 0;
  int         exp_err = 0;
  logic [7:0] m_last_rx = 8'h00;

  // Monitor: counts pulses and flags any key_code change not paired with a strobe.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        prev_kc[i]  = 8'h00;
        prev_vld[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rxv[i]) begin
          vld_cnt[i]++;
          if (i == 0) got_q.push_back(rxb[0]);
        end
        if (ferr[i]) err_cnt[i]++;
        if (stb[i]) stb_cnt[i]++;
        if ((kc[i] != prev_kc[i]) != stb[i]) proto_bad[i]++;
        if (stb[i] && !prev_vld[i]) proto_bad[i]++;
        prev_kc[i]  = kc[i];
        prev_vld[i] = rxv[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: apply one correctly received byte to both tracker flavours.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] old;
    for (int i = 0; i < 2; i++) begin
      old = m_key[i];
      if (b == 8'hF0) begin
        m_brk[i] = 1'b1;
      end else if (b == 8'hE0) begin
        m_ext[i] = 1'b1;
      end else if (EXT_FILTER && m_ext[i]) begin
        m_brk[i] = 1'b0;
        m_ext[i] = 1'b0;
      end else if (m_brk[i]) begin
        if (b == m_key[i] || i == 1) m_key[i] = 8'h00;
        m_brk[i] = 1'b0;
        m_ext[i] = 1'b0;
      end else begin
        m_key[i] = b;
        m_ext[i] = 1'b0;
      end
      if (m_key[i] != old) exp_stb[i]++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_key[i] = 8'h00;
      m_brk[i] = 1'b0;
      m_ext[i] = 1'b0;
    end
    m_last_rx = 8'h00;
  endtask

  task automatic check_state(input string where);
    check({where, ":rx_count0"}, vld_cnt[0], exp_vld);
    check({where, ":rx_count1"}, vld_cnt[1], exp_vld);
    check({where, ":err_count"}, err_cnt[0], exp_err);
    check({where, ":rx_byte"}, rxb[0], m_last_rx);
    check({where, ":key0"}, kc[0], m_key[0]);
    check({where, ":key1"}, kc[1], m_key[1]);
    check({where, ":strobes0"}, stb_cnt[0], exp_stb[0]);
    check({where, ":strobes1"}, stb_cnt[1], exp_stb[1]);
    check({where, ":strobe_timing"}, proto_bad[0] + proto_bad[1], 0);
    check({where, ":rx_q_len"}, got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size()) begin
      while (exp_q.size() > 0) check({where, ":rx_q_byte"}, got_q.pop_front(), exp_q.pop_front());
    end else begin
      got_q.delete();
      exp_q.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit timed);
    logic par;
    logic stop;
    par  = ~^b;
    if (bad_par) par = ~par;
    stop = ~bad_stop;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    if (timed) begin
      // Stop-bit fall: two sync stages, then rx_valid the cycle after the fall.
      ps2_data = stop;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 check("rx_valid_early", rxv[0], 1'b0);
      @(posedge clk);
      #1 check("rx_valid_edge", rxv[0], 1'b1);
      check("rx_byte_edge", rxb[0], b);
      check("key_code_before_strobe", kc[0], 8'h00);
      @(posedge clk);
      #1 check("key_strobe_edge", stb[0], 1'b1);
      check("key_code_edge", kc[0], b);
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end else begin
      ps2_bit(stop);
    end
    ps2_data = 1'b1;
    repeat (6) @(negedge clk);
    if (!bad_par && !bad_stop) begin
      exp_q.push_back(b);
      exp_vld++;
      m_last_rx = b;
      model_byte(b);
    end else begin
      exp_err++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  logic [7:0] codes[7] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h5A, 8'h1D, 8'h24};

  initial begin
    int r;
    logic [7:0] b;

    // Reset state
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset:key0", kc[0], 8'h00);
    check("reset:key1", kc[1], 8'h00);
    check("reset:rx_byte", rxb[0], 8'h00);
    check("reset:pulses", {rxv[0], ferr[0], stb[0], rxv[1], ferr[1], stb[1]}, 6'd0);
    check("reset:state", st[0], 2'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single make, with cycle-exact latency checks
    send_frame(8'h1C, 0, 0, 1);
    check_state("make_1c");

    // Make then break of the same key
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check_state("break_1c");

    // Last key wins; break of a non-held key
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'h1B, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check_state("nonheld_break");
    send_frame(8'h1B, 0, 0, 0);
    check_state("typematic");
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1B, 0, 0, 0);
    check_state("clear_1b");

    // Bad parity and bad stop frames
    send_frame(8'h23, 1, 0, 0);
    send_frame(8'h23, 0, 1, 0);
    check_state("bad_frames");

    // Partial frame abandoned by the inactivity timeout
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (TMO - HALF - 20) @(negedge clk);
    check("timeout_not_yet", err_cnt[0], exp_err);
    repeat (40) @(negedge clk);
    exp_err++;
    check("timeout_fired", err_cnt[0], exp_err);
    send_frame(8'h2B, 0, 0, 0);
    check_state("after_timeout");

    // Extended prefix
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h2B, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h5A, 0, 0, 0);
    check_state("ext_5a");
    check("ext_5a_key", kc[0], EXT_FILTER ? 8'h00 : 8'h5A);
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h5A, 0, 0, 0);
    check_state("ext_break");

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 20) begin
        send_frame(8'hF0, 0, 0, 0);
      end else if (r < 28) begin
        send_frame(8'hE0, 0, 0, 0);
      end else if (r < 34) begin
        b = codes[$urandom_range(0, 6)];
        send_frame(b, 1, 0, 0);
      end else begin
        b = codes[$urandom_range(0, 6)];
        send_frame(b, 0, 0, 0);
      end
      check_state("random");
    end

    // Mid-frame reset
    send_frame(8'h1C, 0, 0, 0);
    check_state("pre_reset");
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst:key0", kc[0], 8'h00);
    check("midrst:key1", kc[1], 8'h00);
    check("midrst:rx_byte", rxb[0], 8'h00);
    check("midrst:pulses", {rxv[0], ferr[0], stb[0], rxv[1], ferr[1], stb[1]}, 6'd0);
    check("midrst:state", st[0], 2'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h2B, 0, 0, 0);
    check_state("post_reset");

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
